// File: rtl/cardinal_pkg.sv
// Shared NIC constants and types for the cardinal node (processor <-> NIC <-> router).
package cardinal_pkg;

    localparam int unsigned DATA_WIDTH = 64;
    localparam int unsigned ADDR_WIDTH = 2;
    // Leftmost packet bit carries the virtual-channel (polarity) tag
    localparam int unsigned VC_BIT     = 0;

    typedef logic [0:DATA_WIDTH-1] packet_t;
    typedef logic [0:ADDR_WIDTH-1] nic_addr_t;

    localparam nic_addr_t NIC_IN_BUF   = 2'b00;
    localparam nic_addr_t NIC_IN_STAT  = 2'b01;
    localparam nic_addr_t NIC_OUT_BUF  = 2'b10;
    localparam nic_addr_t NIC_OUT_STAT = 2'b11;

endpackage

// File: rtl/cardinal_nic_if.sv
// Processor register port plus router local-port handshake seen by the NIC.
interface cardinal_nic_if;
    import cardinal_pkg::*;

    nic_addr_t addr;
    packet_t   d_in;
    packet_t   d_out;
    logic      nicEn;
    logic      nicWrEn;
    logic      net_si;
    logic      net_ri;
    packet_t   net_di;
    logic      net_so;
    logic      net_ro;
    packet_t   net_do;
    logic      net_polarity;

    modport master (
        output addr, d_in, nicEn, nicWrEn, net_si, net_di, net_ro, net_polarity,
        input  d_out, net_ri, net_so, net_do
    );

    modport slave (
        input  addr, d_in, nicEn, nicWrEn, net_si, net_di, net_ro, net_polarity,
        output d_out, net_ri, net_so, net_do
    );

endinterface

// File: rtl/nic_channel_buf.sv
// One-entry packet buffer with a full flag; load only lands when empty.
module nic_channel_buf
    import cardinal_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    load,
    input  logic    drain,
    input  packet_t load_data,
    output packet_t data,
    output logic    full
);

    // Data is kept after a drain so an empty read still returns the last packet
    always_ff @(posedge clk) begin
        if (reset) begin
            data <= '0;
            full <= 1'b0;
        end else if (load && !full) begin
            data <= load_data;
            full <= 1'b1;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/cardinal_nic.sv
// Cardinal NIC: register decode for the processor and polarity-gated router bridge.
module cardinal_nic
    import cardinal_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    cardinal_nic_if.slave  bus
);

    logic    rd_en;
    logic    wr_en;
    logic    in_load;
    logic    in_drain;
    logic    in_full;
    packet_t in_buf;
    logic    out_load;
    logic    out_full;
    packet_t out_buf;
    logic    send;

    assign rd_en    = bus.nicEn & ~bus.nicWrEn;
    assign wr_en    = bus.nicEn &  bus.nicWrEn;

    assign in_load  = bus.net_si & ~in_full;
    assign in_drain = rd_en & (bus.addr == NIC_IN_BUF) & in_full;
    assign out_load = wr_en & (bus.addr == NIC_OUT_BUF) & ~out_full;

    // A packet leaves only when its VC tag matches the router's current phase
    assign send     = out_full & bus.net_ro & (out_buf[VC_BIT] == bus.net_polarity);

    assign bus.net_ri = ~in_full;
    assign bus.net_so = send;
    assign bus.net_do = out_buf;

    nic_channel_buf u_in_buf (
        .clk       (clk),
        .reset     (reset),
        .load      (in_load),
        .drain     (in_drain),
        .load_data (bus.net_di),
        .data      (in_buf),
        .full      (in_full)
    );

    nic_channel_buf u_out_buf (
        .clk       (clk),
        .reset     (reset),
        .load      (out_load),
        .drain     (send),
        .load_data (bus.d_in),
        .data      (out_buf),
        .full      (out_full)
    );

    // Combinational read mux; the processor samples it at the next edge
    always_comb begin
        bus.d_out = '0;
        if (rd_en) begin
            case (bus.addr)
                NIC_IN_BUF:   bus.d_out = in_buf;
                NIC_IN_STAT:  bus.d_out = DATA_WIDTH'(in_full);
                NIC_OUT_STAT: bus.d_out = DATA_WIDTH'(out_full);
                default:      bus.d_out = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_cardinal_nic.sv
// Directed bench for cardinal_nic with a queue-based reference model checked every cycle.
module tb_cardinal_nic;

    logic clk = 1'b0;
    logic reset = 1'b1;
    bit   armed = 1'b0;
    int   tests = 0;
    int   fails = 0;

    cardinal_nic_if bus ();

    cardinal_nic dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: each channel holds at most one packet; the leftmost bit is the VC tag
    logic [63:0] in_q[$];
    logic [63:0] out_q[$];
    logic [63:0] last_in  = '0;
    logic [63:0] last_out = '0;

    function automatic logic model_so();
        return out_q.size() != 0 && bus.net_ro && (out_q[0][63] == bus.net_polarity);
    endfunction

    function automatic logic [63:0] model_d_out();
        if (!(bus.nicEn && !bus.nicWrEn)) return 64'd0;
        case (int'(bus.addr))
            0:       return last_in;
            1:       return (in_q.size() != 0) ? 64'd1 : 64'd0;
            3:       return (out_q.size() != 0) ? 64'd1 : 64'd0;
            default: return 64'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        if (reset) begin
            in_q.delete();
            out_q.delete();
            last_in  = '0;
            last_out = '0;
        end else begin
            logic pop_in, push_in, pop_out, push_out;
            pop_in   = bus.nicEn && !bus.nicWrEn && int'(bus.addr) == 0 && in_q.size() != 0;
            push_in  = bus.net_si && in_q.size() == 0;
            pop_out  = model_so();
            push_out = bus.nicEn && bus.nicWrEn && int'(bus.addr) == 2 && out_q.size() == 0;
            if (pop_in) void'(in_q.pop_front());
            if (push_in) begin
                in_q.push_back(bus.net_di);
                last_in = bus.net_di;
            end
            if (pop_out) void'(out_q.pop_front());
            if (push_out) begin
                out_q.push_back(bus.d_in);
                last_out = bus.d_in;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (armed) begin
            chk("model_d_out",  bus.d_out,  model_d_out());
            chk("model_net_ri", 64'(bus.net_ri), 64'(in_q.size() == 0));
            chk("model_net_so", 64'(bus.net_so), 64'(model_so()));
            chk("model_net_do", bus.net_do, last_out);
        end
    end

    task automatic idle();
        bus.nicEn = 1'b0; bus.nicWrEn = 1'b0; bus.addr = 2'b00; bus.d_in = '0;
        bus.net_si = 1'b0; bus.net_di = '0; bus.net_ro = 1'b0; bus.net_polarity = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic rd(input logic [1:0] a);
        bus.nicEn = 1'b1; bus.nicWrEn = 1'b0; bus.addr = a;
    endtask

    task automatic wr(input logic [1:0] a, input logic [63:0] d);
        bus.nicEn = 1'b1; bus.nicWrEn = 1'b1; bus.addr = a; bus.d_in = d;
    endtask

    initial begin
        idle();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        armed = 1'b1;

        // Reset then idle
        smp(); chk("rst_d_out", bus.d_out, 64'd0); chk("rst_ri", 64'(bus.net_ri), 64'd1);
        chk("rst_so", 64'(bus.net_so), 64'd0); chk("rst_do", bus.net_do, 64'd0);
        step(); rd(2'b01); smp(); chk("idle_in_stat", bus.d_out, 64'd0);
        step(); rd(2'b11); smp(); chk("idle_out_stat", bus.d_out, 64'd0);

        // Ingress, a protocol-violating second send, then drain
        step(); bus.nicEn = 1'b0; bus.net_si = 1'b1; bus.net_di = 64'hDEAD_BEEF_0000_0001;
        smp(); chk("ing_ri_empty", 64'(bus.net_ri), 64'd1);
        step(); bus.net_di = 64'h0000_0000_0000_0BAD; rd(2'b01);
        smp(); chk("ing_ri_full", 64'(bus.net_ri), 64'd0); chk("ing_in_stat", bus.d_out, 64'd1);
        step(); bus.net_si = 1'b0; rd(2'b00);
        smp(); chk("ing_read", bus.d_out, 64'hDEAD_BEEF_0000_0001);
        step(); rd(2'b01);
        smp(); chk("ing_drained", bus.d_out, 64'd0); chk("ing_ri_again", 64'(bus.net_ri), 64'd1);
        step(); rd(2'b00);
        smp(); chk("ing_stale", bus.d_out, 64'hDEAD_BEEF_0000_0001);

        // Egress gated by polarity (VC bit 0)
        step(); wr(2'b10, 64'h0123_4567_89AB_CDEF); bus.net_ro = 1'b1; bus.net_polarity = 1'b1;
        smp(); chk("egr_empty_so", 64'(bus.net_so), 64'd0);
        step(); bus.nicEn = 1'b0;
        smp(); chk("egr_wrong_pol", 64'(bus.net_so), 64'd0); chk("egr_do", bus.net_do, 64'h0123_4567_89AB_CDEF);
        step(); bus.net_polarity = 1'b0;
        smp(); chk("egr_send", 64'(bus.net_so), 64'd1); chk("egr_send_do", bus.net_do, 64'h0123_4567_89AB_CDEF);
        step(); rd(2'b11);
        smp(); chk("egr_once", 64'(bus.net_so), 64'd0); chk("egr_out_stat", bus.d_out, 64'd0);

        // Writes while full are dropped
        step(); bus.net_ro = 1'b0; wr(2'b10, 64'h1111); smp();
        step(); wr(2'b10, 64'h2222); smp();
        step(); rd(2'b11);
        smp(); chk("drop_full", bus.d_out, 64'd1); chk("drop_do", bus.net_do, 64'h1111);
        step(); bus.nicEn = 1'b0; bus.net_ro = 1'b1; bus.net_polarity = 1'b0;
        smp(); chk("drop_send", 64'(bus.net_so), 64'd1); chk("drop_send_do", bus.net_do, 64'h1111);
        step(); bus.net_ro = 1'b0; rd(2'b11);
        smp(); chk("drop_empty", bus.d_out, 64'd0); chk("drop_never", bus.net_do, 64'h1111);

        // Ingress, processor write and router ready in one cycle
        step(); bus.net_si = 1'b1; bus.net_di = 64'hAAAA_5555_AAAA_5555;
        wr(2'b10, 64'h8000_0000_0000_0005); bus.net_ro = 1'b1; bus.net_polarity = 1'b0;
        smp(); chk("sim_ri", 64'(bus.net_ri), 64'd1);
        step(); bus.net_si = 1'b0; rd(2'b01);
        smp(); chk("sim_in_full", bus.d_out, 64'd1); chk("sim_ri_low", 64'(bus.net_ri), 64'd0);
        chk("sim_so_mismatch", 64'(bus.net_so), 64'd0);
        step(); rd(2'b11);
        smp(); chk("sim_out_full", bus.d_out, 64'd1);
        step(); bus.nicEn = 1'b0; bus.net_polarity = 1'b1;
        smp(); chk("sim_so_match", 64'(bus.net_so), 64'd1); chk("sim_do", bus.net_do, 64'h8000_0000_0000_0005);
        step(); bus.net_ro = 1'b0; bus.net_polarity = 1'b0;

        // Reset with both buffers full discards everything
        wr(2'b10, 64'h5); smp();
        step(); rd(2'b11); reset = 1'b1;
        smp(); chk("pre_rst_out", bus.d_out, 64'd1); chk("pre_rst_ri", 64'(bus.net_ri), 64'd0);
        step(); reset = 1'b0; bus.net_ro = 1'b1; bus.net_polarity = 1'b0; rd(2'b01);
        smp(); chk("mid_rst_in", bus.d_out, 64'd0); chk("mid_rst_ri", 64'(bus.net_ri), 64'd1);
        chk("mid_rst_so", 64'(bus.net_so), 64'd0);
        step(); rd(2'b11);
        smp(); chk("mid_rst_out", bus.d_out, 64'd0); chk("mid_rst_do", bus.net_do, 64'd0);
        step(); rd(2'b00);
        smp(); chk("mid_rst_buf", bus.d_out, 64'd0);
        step(); idle();
        smp(); chk("end_d_out", bus.d_out, 64'd0);

        step();
        armed = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cardinal_nic.md
Name: cardinal_nic

Overview:
- Network interface controller at the processor's NIC port. It is the responder to the processor's nicEn/nicWrEn/nic_addr/d_out access and the source of its nic_data.
- Holds one-entry input and output channel buffers, each with a status flag.
- Bridges the processor to the mesh router's local port using a send/ready handshake with a polarity (virtual-channel) gate.
- One instance per node, between cardinal_processor and the router.

Parameters:
- DATA_WIDTH, 64, width of packets, buffers and processor data.
- ADDR_WIDTH, 2, NIC register address width.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- addr  in  2  [0:1] register select: 00 input buffer, 01 input status, 10 output buffer, 11 output status
- d_in  in  64  [0:63] write data from processor
- d_out  out  64  [0:63] read data to processor
- nicEn  in  1  access enable
- nicWrEn  in  1  1 = write, 0 = read; only valid with nicEn
- net_si  in  1  router sends packet into NIC
- net_ri  out  1  NIC ready to accept from router
- net_di  in  64  packet from router
- net_so  out  1  NIC sends packet to router
- net_ro  in  1  router ready to accept from NIC
- net_do  out  64  packet to router
- net_polarity  in  1  router's current even/odd cycle phase

Behaviour:
- State:
  - in_buf[0:63] and in_full.
  - out_buf[0:63] and out_full.
  - All four clear to 0 on reset, and reset overrides every concurrent event.
- Reset values of the outputs:
  - d_out = 0 and net_so = 0.
  - net_ri = 1 (derived from in_full = 0).
  - net_do = 0 (out_buf cleared).
- Processor read (nicEn=1, nicWrEn=0) is combinational. d_out is valid in the same cycle, because the processor samples it at the next posedge.
  - addr 00: d_out = in_buf. If in_full=1, in_full clears at that posedge. Reading while empty returns stale in_buf and changes no state.
  - addr 01: d_out = {63'b0, in_full}.
  - addr 11: d_out = {63'b0, out_full}.
  - addr 10: d_out = 0.
  - d_out = 0 whenever nicEn=0 or nicWrEn=1.
- Processor write (nicEn=1, nicWrEn=1):
  - addr 10 with out_full=0: out_buf <= d_in and out_full <= 1 at the posedge.
  - addr 10 with out_full=1: the write is dropped silently and out_buf is unchanged. Software must poll addr 11 before writing.
  - Writes to addr 00, 01 or 11 are ignored.
- Router ingress:
  - net_ri = ~in_full, combinational.
  - When net_si=1 and net_ri=1 at a posedge: in_buf <= net_di and in_full <= 1.
  - net_si while net_ri=0 is a router protocol violation; the NIC ignores it.
  - A processor read of addr 00 and an ingress cannot coincide, because ingress requires in_full=0. The next packet is accepted one cycle after the drain at the earliest.
- Router egress:
  - net_do = out_buf at all times.
  - net_so = out_full & net_ro & (out_buf[0] == net_polarity). Bit 0 of the packet is its VC bit, and a packet leaves only in the matching polarity phase.
  - When net_so=1, out_full clears at that posedge.
  - A processor write to addr 10 in the same cycle as a send is dropped, because the write sees out_full=1. No back-to-back refill occurs within a single cycle.
- Latencies:
  - Processor write to earliest net_so: 1 cycle.
  - net_si accept to in_full visible at addr 01: 1 cycle.
- Ingress, egress and a processor access to the other buffer are independent and may all occur in the same cycle.

Decomposition:
- Shared package cardinal_pkg holds:
  - NIC address constants: NIC_IN_BUF=2'b00, NIC_IN_STAT=2'b01, NIC_OUT_BUF=2'b10, NIC_OUT_STAT=2'b11.
  - DATA_WIDTH.
  - The packet VC-bit index constant (0).
- One natural sub-module, nic_channel_buf: a one-entry buffer with full flag, load and drain inputs, and data and full outputs. It is instantiated twice, once for input and once for output. The top level adds the address decode, the read mux and the polarity gate.

Test Plan:
- Reset then idle:
  - d_out=0, net_ri=1, net_so=0.
  - Read addr 01 and addr 11 -> both return 0.
- Ingress then read:
  - Drive net_si=1, net_di=64'hDEAD_BEEF_0000_0001 for one cycle -> net_ri=0 next cycle and addr 01 reads 1.
  - Read addr 00 -> d_out=64'hDEAD_BEEF_0000_0001 in the same cycle; next cycle addr 01 reads 0 and net_ri=1.
- Egress with polarity, VC bit 0:
  - Write addr 10 with d_in=64'h0123_4567_89AB_CDEF, net_ro=1, net_polarity=1 -> net_so stays 0.
  - Toggle net_polarity to 0 -> net_so=1 with net_do=64'h0123_4567_89AB_CDEF for exactly one cycle; addr 11 then reads 0.
- Output full drop:
  - With out_full=1 and net_ro=0, write 64'h1111 then 64'h2222.
  - Release with net_ro=1 and matching polarity -> net_do=64'h1111; the 64'h2222 write is never seen.
- Simultaneous events: in one cycle net_si=1 (in empty), a processor write to addr 10 (out empty), and net_ro=1 -> both buffers show full next cycle, and net_so asserts only once polarity matches.
- Reset mid-operation: with both buffers full, assert reset for one cycle -> in_full=out_full=0, net_ri=1, net_so=0, d_out=0, and the buffered packets are discarded.
